// File: rtl/gate_width_meter.sv
// Gate width meter: times each gate between pulse_up and pulse_dn strobes and hands
// (width, seq, sat) to downstream logic through a single-entry valid/ready register.
module gate_width_meter #(
   parameter int unsigned WIDTH_W = 16,
   parameter int unsigned SEQ_W   = 8
) (
   input  logic               clk_o,
   input  logic               resetn_i,
   input  logic               pulse_up,
   input  logic               pulse_dn,
   input  logic               clear_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [WIDTH_W-1:0] width_o,
   output logic [SEQ_W-1:0]   seq_o,
   output logic               sat_o,
   output logic               overrun_o,
   output logic               proto_err_o
);

   localparam logic [0:0]         StIdle = 1'b0;
   localparam logic [0:0]         StOpen = 1'b1;
   localparam logic [WIDTH_W-1:0] CntMax = '1;

   logic [0:0]         state_q, state_d;
   logic [WIDTH_W-1:0] cnt_q, cnt_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic               valid_q, valid_d;
   logic [WIDTH_W-1:0] width_q, width_d;
   logic [SEQ_W-1:0]   seq_out_q, seq_out_d;
   logic               sat_q, sat_d;
   logic               overrun_q, overrun_d;
   logic               proto_q, proto_d;

   logic [WIDTH_W:0]   cnt_inc;
   logic               done;

   // Extra MSB of the increment doubles as the saturation indicator.
   assign cnt_inc = {1'b0, cnt_q} + {{WIDTH_W{1'b0}}, 1'b1};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      seq_d     = seq_q;
      valid_d   = valid_q;
      width_d   = width_q;
      seq_out_d = seq_out_q;
      sat_d     = sat_q;
      overrun_d = overrun_q;
      proto_d   = proto_q;
      done      = 1'b0;

      if (pulse_up && pulse_dn) begin
         proto_d = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (pulse_up) begin
                  state_d = StOpen;
                  cnt_d   = '0;
               end else if (pulse_dn) begin
                  proto_d = 1'b1;
               end
            end
            default: begin
               if (pulse_dn) begin
                  state_d = StIdle;
                  done    = 1'b1;
               end else if (pulse_up) begin
                  cnt_d   = '0;
                  proto_d = 1'b1;
               end else if (cnt_q != CntMax) begin
                  cnt_d = cnt_inc[WIDTH_W-1:0];
               end
            end
         endcase
      end

      if (done) begin
         // Dropped results still consume a sequence number.
         seq_d = seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
         if (!valid_q || ready_i) begin
            valid_d   = 1'b1;
            width_d   = cnt_inc[WIDTH_W] ? CntMax : cnt_inc[WIDTH_W-1:0];
            sat_d     = cnt_inc[WIDTH_W];
            seq_out_d = seq_q;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      if (clear_i) begin
         state_d   = StIdle;
         cnt_d     = '0;
         seq_d     = '0;
         valid_d   = 1'b0;
         width_d   = '0;
         seq_out_d = '0;
         sat_d     = 1'b0;
         overrun_d = 1'b0;
         proto_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_o or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         seq_q     <= '0;
         valid_q   <= 1'b0;
         width_q   <= '0;
         seq_out_q <= '0;
         sat_q     <= 1'b0;
         overrun_q <= 1'b0;
         proto_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         seq_q     <= seq_d;
         valid_q   <= valid_d;
         width_q   <= width_d;
         seq_out_q <= seq_out_d;
         sat_q     <= sat_d;
         overrun_q <= overrun_d;
         proto_q   <= proto_d;
      end
   end

   assign valid_o     = valid_q;
   assign width_o     = width_q;
   assign seq_o       = seq_out_q;
   assign sat_o       = sat_q;
   assign overrun_o   = overrun_q;
   assign proto_err_o = proto_q;

endmodule
